pipe_adder_n: RTL and testbench
===============================

// Module: pipe_adder_n
// PURPOSE
//  Parametrised, pipelined ripple-carry adder: WIDTH-bit a + b + cin -> (WIDTH+1)-bit sum.
//  Operand is cut into STAGES equal slices; slice k is added in pipeline stage k, and its carry is registered into stage k+1.
//  Valid/ready handshake on both sides with per-stage backpressure.
//  Drop-in sequential successor to our small combinational adders in the auto-pipeline flow.
// PARAMETERS
//  WIDTH   8  operand width in bits; WIDTH % STAGES must be 0 (elaboration error otherwise)
//  STAGES  2  number of register stages = latency in cycles; 1..WIDTH
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operands a, b, cin valid this cycle
//  in_ready   out  1        stage 0 can accept; transfer when in_valid & in_ready
//  a          in   WIDTH    operand A (unsigned; two's-complement view only for ovf)
//  b          in   WIDTH    operand B
//  cin        in   1        carry in to bit 0
//  out_valid  out  1        sum valid
//  out_ready  in   1        consumer accepts; transfer when out_valid & out_ready
//  sum        out  WIDTH+1  a+b+cin; sum[WIDTH] = carry out
//  ovf        out  1        signed overflow, aligned with sum (only with PIPE_ADDER_OVF_EN)
// BEHAVIOUR
//  - SW = WIDTH/STAGES. Stage k (0..STAGES-1) holds: valid v[k], carry c[k], finished low sum bits
//    [(k+1)*SW-1:0], and remaining high operand slices of a and b still to be added.
//  - Stage 0 captures a[SW-1:0]+b[SW-1:0]+cin plus a/b upper slices; stage k adds slice k using c[k-1].
//  - Last stage drives sum = {c[STAGES-1], low bits}; out_valid = v[STAGES-1].
//  - Advance rule: rdy[STAGES-1] = !v[STAGES-1] | out_ready; rdy[k] = !v[k] | rdy[k+1];
//    in_ready = rdy[0]. A stage loads when its rdy is 1 (valid from upstream, or bubble).
//  - Bubbles collapse: an empty stage accepts even while downstream stalls.
//  - Stalled stages hold all contents unchanged; sum/ovf stable while out_valid & !out_ready.
//  - Latency: exactly STAGES cycles from accept to out_valid with out_ready held 1.
//  - Throughput: one result per cycle when out_ready held 1.
//  - Ordering strictly FIFO; no reordering, no drops, no duplicates.
//  - Width rule: sum = (a + b + cin) mod 2^(WIDTH+1); never truncated.
//  - Data registers load only on advance (no clock gating); data of invalid stages is don't-care
//    internally, but sum outputs 0 until the first valid result leaves.
//  - Reset (any time, incl. mid-operation): all v[k]=0, carries 0, sum=0, out_valid=0, ovf=0;
//    in-flight operands discarded; in_ready=1 while reset is deasserted and pipe empty.
//  - Simultaneous out transfer and in transfer on a full pipe: allowed, pipe stays full.
//  - STAGES=1: single registered adder, in_ready = !out_valid | out_ready.
//  - STAGES=WIDTH: 1-bit slices, bit-serial carry chain across stages.
// CONFIGURATION
//  - PIPE_ADDER_OVF_EN defined:
//    - port ovf present;
//    - ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]) for W=WIDTH, computed in the last stage;
//    - sign bits of a, b are carried alongside the slice data to do so;
//    - reset 0, held on stall.
//  - PIPE_ADDER_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.
// TESTING (WIDTH=8, STAGES=2 unless noted)
//  1. Reset: assert rst_n=0 -> out_valid=0, sum=9'h000, in_ready=1 after release.
//  2. a=8'hFF b=8'h01 cin=0 accepted, out_ready=1 -> out_valid=1, sum=9'h100 exactly 2 cycles later.
//  3. Stream a=1,2,3,4 with b=8'h10, cin=1, out_ready=1 -> sums 9'h012,013,014,015 on 4 consecutive cycles, in order.
//  4. Fill pipe, hold out_ready=0 for 3 cycles -> in_ready=0 by 2nd cycle, sum held constant,
//     then out_ready=1 -> all results delivered, none lost.
//  5. rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately, no stale sum after release.
//  6. PIPE_ADDER_OVF_EN: 8'h7F+8'h01 -> ovf=1; 8'h80+8'hFF -> ovf=1, sum=9'h17F; 8'h01+8'h01 -> ovf=0.
//     Repeat 2-3 with STAGES=1, 4 and 8 -> same sums, latency = STAGES.

Source files
------------

// File: rtl/pipe_adder_n.sv
// pipe_adder_n: STAGES-deep pipelined ripple-carry adder with valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder_n #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef PIPE_ADDER_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_adder_n: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] c;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_v;

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = !v[k] || chain;
            rdy[k] = chain;
        end
    end

    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) up_v[k] = v[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LW = (k + 1) * SW;

        logic [SW-1:0] op_a;
        logic [SW-1:0] op_b;
        logic          c_in;
        logic [SW:0]   add;
        logic [LW-1:0] lo;
        logic [LW-1:0] lo_next;
        logic          load;
`ifdef PIPE_ADDER_OVF_EN
        logic          sa_in;
        logic          sb_in;
`endif

        if (k == 0) begin : g_first
            assign op_a    = a[SW-1:0];
            assign op_b    = b[SW-1:0];
            assign c_in    = cin;
            assign lo_next = add[SW-1:0];
`ifdef PIPE_ADDER_OVF_EN
            assign sa_in   = a[WIDTH-1];
            assign sb_in   = b[WIDTH-1];
`endif
        end else begin : g_next
            assign op_a    = g_stage[k-1].g_ops.a_rem[SW-1:0];
            assign op_b    = g_stage[k-1].g_ops.b_rem[SW-1:0];
            assign c_in    = c[k-1];
            assign lo_next = {add[SW-1:0], g_stage[k-1].lo};
`ifdef PIPE_ADDER_OVF_EN
            assign sa_in   = g_stage[k-1].g_ops.sa;
            assign sb_in   = g_stage[k-1].g_ops.sb;
`endif
        end

        assign add  = (SW+1)'(op_a) + (SW+1)'(op_b) + (SW+1)'(c_in);
        assign load = rdy[k] && up_v[k];

        // Data only moves with a valid item, so the output sum stays 0 until the first result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k] <= 1'b0;
                c[k] <= 1'b0;
                lo   <= '0;
            end else begin
                if (rdy[k]) v[k] <= up_v[k];
                if (load) begin
                    c[k] <= add[SW];
                    lo   <= lo_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            localparam int RW = WIDTH - LW;
            logic [RW-1:0] a_rem;
            logic [RW-1:0] b_rem;
            logic [RW-1:0] a_next;
            logic [RW-1:0] b_next;
`ifdef PIPE_ADDER_OVF_EN
            logic          sa;
            logic          sb;
`endif

            if (k == 0) begin : g_src_in
                assign a_next = a[WIDTH-1:SW];
                assign b_next = b[WIDTH-1:SW];
            end else begin : g_src_prev
                assign a_next = g_stage[k-1].g_ops.a_rem[WIDTH-k*SW-1:SW];
                assign b_next = g_stage[k-1].g_ops.b_rem[WIDTH-k*SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem <= '0;
                    b_rem <= '0;
`ifdef PIPE_ADDER_OVF_EN
                    sa    <= 1'b0;
                    sb    <= 1'b0;
`endif
                end else if (load) begin
                    a_rem <= a_next;
                    b_rem <= b_next;
`ifdef PIPE_ADDER_OVF_EN
                    sa    <= sa_in;
                    sb    <= sb_in;
`endif
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // The top slice's sum MSB is bit WIDTH-1 of the full result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ovf <= 1'b0;
                else if (load) ovf <= (sa_in == sb_in) && (add[SW-1] != sa_in);
            end
        end
`endif
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign sum       = {c[STAGES-1], g_stage[STAGES-1].lo};

endmodule

// File: tb/tb_pipe_adder_n.sv
// tb_pipe_adder_n: directed checks of pipe_adder_n at WIDTH=8 with STAGES=1,2,4,8 side by side.
// Index 1 (STAGES=2) is the main instance for the stall and reset scenarios.
module tb_pipe_adder_n;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [3:0] ov;
    logic [3:0] ir;
    logic [8:0] sm [4];
`ifdef PIPE_ADDER_OVF_EN
    logic [3:0] of;
`endif

    int checks   = 0;
    int failures = 0;
    int lat [4]  = '{1, 2, 4, 8};

    pipe_adder_n #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0])
`ifdef PIPE_ADDER_OVF_EN
       ,.ovf(of[0])
`endif
    );
    pipe_adder_n #(.WIDTH(8), .STAGES(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1])
`ifdef PIPE_ADDER_OVF_EN
       ,.ovf(of[1])
`endif
    );
    pipe_adder_n #(.WIDTH(8), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2])
`ifdef PIPE_ADDER_OVF_EN
       ,.ovf(of[2])
`endif
    );
    pipe_adder_n #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[3]), .out_ready(out_ready), .sum(sm[3])
`ifdef PIPE_ADDER_OVF_EN
       ,.ovf(of[3])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov[i] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_out_valid[%0d]: got %b expected 0", i, ov[i]);
            end
            checks++;
            if (sm[i] !== 9'h000) begin
                failures++;
                $display("[TB] FAIL reset_sum[%0d]: got %h expected 000", i, sm[i]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ir[i] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_in_ready[%0d]: got %b expected 1", i, ir[i]);
            end
        end
    endtask

    task automatic test_single();
        a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ov[i] !== (n == lat[i])) begin
                    failures++;
                    $display("[TB] FAIL single_valid[%0d] cycle %0d: got %b expected %b", i, n, ov[i], (n == lat[i]));
                end
                if (n < lat[i]) begin
                    checks++;
                    if (sm[i] !== 9'h000) begin
                        failures++;
                        $display("[TB] FAIL single_early_sum[%0d] cycle %0d: got %h expected 000", i, n, sm[i]);
                    end
                end else if (n == lat[i]) begin
                    checks++;
                    if (sm[i] !== 9'h100) begin
                        failures++;
                        $display("[TB] FAIL single_sum[%0d]: got %h expected 100", i, sm[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            if (n < 4) begin
                in_valid = 1'b1; a = 8'(n + 1); b = 8'h10; cin = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                int  j;
                logic exp_v;
                j     = n + 1 - lat[i];
                exp_v = (j >= 0) && (j < 4);
                checks++;
                if (ov[i] !== exp_v) begin
                    failures++;
                    $display("[TB] FAIL stream_valid[%0d] cycle %0d: got %b expected %b", i, n + 1, ov[i], exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (sm[i] !== 9'(9'h012 + j)) begin
                        failures++;
                        $display("[TB] FAIL stream_sum[%0d] item %0d: got %h expected %h", i, j, sm[i], 9'(9'h012 + j));
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h20; b = 8'h01; cin = 1'b0;
        tick();
        checks++;
        if (ir[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_ready_first: got %b expected 1", ir[1]);
        end
        a = 8'h30; b = 8'h02;
        tick();
        a = 8'h40; b = 8'h03;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) tick();
            checks++;
            if (ir[1] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_in_ready cycle %0d: got %b expected 0", n, ir[1]);
            end
            checks++;
            if (ov[1] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stall_out_valid cycle %0d: got %b expected 1", n, ov[1]);
            end
            checks++;
            if (sm[1] !== 9'h021) begin
                failures++;
                $display("[TB] FAIL stall_sum_held cycle %0d: got %h expected 021", n, sm[1]);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_release_ready: got %b expected 1", ir[1]);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (ov[1] !== 1'b1 || sm[1] !== 9'h032) begin
            failures++;
            $display("[TB] FAIL stall_drain_1: got v=%b sum=%h expected v=1 sum=032", ov[1], sm[1]);
        end
        tick();
        checks++;
        if (ov[1] !== 1'b1 || sm[1] !== 9'h043) begin
            failures++;
            $display("[TB] FAIL stall_drain_2: got v=%b sum=%h expected v=1 sum=043", ov[1], sm[1]);
        end
        tick();
        checks++;
        if (ov[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_drain_end: got %b expected 0", ov[1]);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h05; b = 8'h06; cin = 1'b0;
        tick();
        a = 8'h07; b = 8'h08;
        tick();
        in_valid = 1'b0;
        checks++;
        if (ov[1] !== 1'b1 || sm[1] !== 9'h00B) begin
            failures++;
            $display("[TB] FAIL midreset_pre: got v=%b sum=%h expected v=1 sum=00b", ov[1], sm[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov[1] !== 1'b0 || sm[1] !== 9'h000) begin
            failures++;
            $display("[TB] FAIL midreset_immediate: got v=%b sum=%h expected v=0 sum=000", ov[1], sm[1]);
        end
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ov[i] !== 1'b0 || sm[i] !== 9'h000 || ir[i] !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL midreset_after[%0d] cycle %0d: got v=%b sum=%h rdy=%b expected v=0 sum=000 rdy=1",
                             i, n, ov[i], sm[i], ir[i]);
                end
            end
        end
    endtask

`ifdef PIPE_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] va [3] = '{8'h7F, 8'h80, 8'h01};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h01};
        logic [8:0] es [3] = '{9'h080, 9'h17F, 9'h002};
        logic       eo [3] = '{1'b1, 1'b1, 1'b0};
        out_ready = 1'b1; cin = 1'b0;
        for (int n = 0; n <= 11; n++) begin
            if (n < 3) begin
                in_valid = 1'b1; a = va[n]; b = vb[n];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                int j;
                j = n + 1 - lat[i];
                if (j < 0) begin
                    checks++;
                    if (of[i] !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL ovf_idle[%0d]: got %b expected 0", i, of[i]);
                    end
                end else if (j < 3) begin
                    checks++;
                    if (ov[i] !== 1'b1 || sm[i] !== es[j] || of[i] !== eo[j]) begin
                        failures++;
                        $display("[TB] FAIL ovf_item[%0d] %0d: got v=%b sum=%h ovf=%b expected v=1 sum=%h ovf=%b",
                                 i, j, ov[i], sm[i], of[i], es[j], eo[j]);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_reset_mid();
`ifdef PIPE_ADDER_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
